// File: rtl/port_uart_tx_if.sv
// port_uart_tx_if
//   Bundles the processor-side output port strobe/data and the UART stage
//   status lines.
//   master : the processor side; drives PortWrite/PortData, observes status.
//   slave  : the UART stage; samples PortWrite/PortData, drives Tx, Busy,
//            Full and Overflow.
interface port_uart_tx_if;
  logic        PortWrite;
  logic [31:0] PortData;
  logic        Tx;
  logic        Busy;
  logic        Full;
  logic        Overflow;

  modport master (
    output PortWrite,
    output PortData,
    input  Tx,
    input  Busy,
    input  Full,
    input  Overflow
  );

  modport slave (
    input  PortWrite,
    input  PortData,
    output Tx,
    output Busy,
    output Full,
    output Overflow
  );
endinterface

// File: rtl/port_uart_tx.sv
// port_uart_tx
//   Buffers 32-bit words from the processor output port in a small FIFO and
//   sends each word as four 8N1 UART frames, byte 0 first, LSB first.
//   Ports:
//     clk   : system clock, rising edge
//     reset : synchronous, active-low
//     port  : slave side of port_uart_tx_if
//             PortWrite/PortData in; Tx, Busy, Full, Overflow out (all
//             registered)
//   Parameters:
//     CLKS_PER_BIT : clock cycles per UART bit (>= 2)
//     FIFO_DEPTH   : buffered words (power of two, >= 2)
module port_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           reset,
  port_uart_tx_if.slave  port
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ZERO = {BW{1'b0}};
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ZERO  = {(AW + 1){1'b0}};
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [31:0]     shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            full_q, full_d;
  logic            ovf_q, ovf_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [31:0]     mem_q [FIFO_DEPTH];

  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic            push_s;
  logic            pop_s;
  logic            bit_done_s;
  logic [7:0]      cur_byte_s;

  // Full is judged on the pre-edge count, so a same-edge pop never makes room.
  assign fifo_full_s  = (count_q == CNT_FULL);
  assign fifo_empty_s = (count_q == CNT_ZERO);
  assign push_s       = port.PortWrite & ~fifo_full_s;
  assign bit_done_s   = (baud_q == BAUD_LAST);
  assign cur_byte_s   = shift_q[{byte_idx_q, 3'b000} +: 8];

  // FSM next state, baud/bit/byte counters, pop request and next Tx level.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q + BAUD_ONE;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    pop_s      = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = BAUD_ZERO;
        tx_d   = 1'b1;
        if (!fifo_empty_s) begin
          pop_s      = 1'b1;
          shift_d    = mem_q[rd_ptr_q];
          byte_idx_d = 2'd0;
          state_d    = S_START;
          tx_d       = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bit_done_s) begin
          baud_d    = BAUD_ZERO;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
          tx_d      = cur_byte_s[0];
        end else begin
          tx_d = 1'b0;
        end
      end
      S_DATA: begin
        if (bit_done_s) begin
          baud_d = BAUD_ZERO;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = cur_byte_s[bit_idx_q + 3'd1];
          end
        end else begin
          tx_d = tx_q;
        end
      end
      S_STOP: begin
        if (bit_done_s) begin
          baud_d = BAUD_ZERO;
          if (byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = S_START;
            tx_d       = 1'b0;
          end else if (!fifo_empty_s) begin
            // Back-to-back words: next start bit follows this stop bit directly.
            pop_s      = 1'b1;
            shift_d    = mem_q[rd_ptr_q];
            byte_idx_d = 2'd0;
            state_d    = S_START;
            tx_d       = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          tx_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = BAUD_ZERO;
        tx_d    = 1'b1;
      end
    endcase
  end

  // FIFO pointers/count, sticky overflow and registered status outputs.
  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    ovf_d  = ovf_q | (port.PortWrite & fifo_full_s);
    busy_d = (state_d != S_IDLE);
    full_d = (count_d == CNT_FULL);
  end

  // State and control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      baud_q     <= BAUD_ZERO;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 2'd0;
      shift_q    <= 32'h0000_0000;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= PTR_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      count_q    <= CNT_ZERO;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers/count gate use.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= port.PortData;
    end
  end

  assign port.Tx       = tx_q;
  assign port.Busy     = busy_q;
  assign port.Full     = full_q;
  assign port.Overflow = ovf_q;

endmodule

// File: tb/tb_port_uart_tx.sv
// tb_port_uart_tx
//   Directed bench for port_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
//   Tx/Busy are logged once per cycle (index = number of rising edges seen)
//   and whole frames are compared against waveforms built from the expected
//   bytes.
module tb_port_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int HMAX  = 8192;

  logic clk = 1'b0;
  logic reset;
  port_uart_tx_if bus ();

  port_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .port  (bus)
  );

  always #5 clk = ~clk;

  int   edge_cnt = 0;
  logic tx_hist   [HMAX];
  logic busy_hist [HMAX];
  int   n_vec = 0;
  int   n_err = 0;

  // Count rising edges.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Log outputs mid-cycle: entry n is the value after rising edge n.
  always @(negedge clk) begin
    if (edge_cnt < HMAX) begin
      tx_hist[edge_cnt]   <= bus.Tx;
      busy_hist[edge_cnt] <= bus.Busy;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] w);
    bus.PortWrite = 1'b1;
    bus.PortData  = w;
    tick(1);
    bus.PortWrite = 1'b0;
  endtask

  // Advance until history entry idx has been logged.
  task automatic wait_hist(input int idx);
    while (edge_cnt <= idx) tick(1);
  endtask

  task automatic wait_edge(input int idx);
    while (edge_cnt < idx) tick(1);
  endtask

  task automatic check_byte(input string tag, input int start, input logic [7:0] b);
    logic [10*CPB-1:0] exp_w;
    logic [10*CPB-1:0] obs_w;
    logic [9:0]        frame;
    frame = {1'b1, b, 1'b0};
    for (int c = 0; c < 10 * CPB; c++) begin
      exp_w[c] = frame[c / CPB];
      obs_w[c] = tx_hist[start + c];
    end
    chk(tag, 64'(obs_w), 64'(exp_w));
  endtask

  task automatic check_word(input string tag, input int start, input logic [31:0] w);
    wait_hist(start + 40 * CPB - 1);
    for (int b = 0; b < 4; b++)
      check_byte($sformatf("%s b%0d", tag, b), start + 10 * CPB * b, w[8*b +: 8]);
  endtask

  function automatic int busy_cnt(input int a, input int z);
    int n;
    n = 0;
    for (int i = a; i <= z; i++) if (busy_hist[i] === 1'b1) n++;
    return n;
  endfunction

  logic [31:0] words [6];
  int s;

  initial begin
    words[0] = 32'hDEADBEEF;
    words[1] = 32'h01234567;
    words[2] = 32'h89ABCDEF;
    words[3] = 32'hCAFEF00D;
    words[4] = 32'h5A5A0FF0;
    words[5] = 32'h77777777;
    reset = 1'b0;
    bus.PortWrite = 1'b0;
    bus.PortData  = 32'h0000_0000;

    // 1: reset held two cycles
    tick(2);
    reset = 1'b1;
    tick(1);
    chk("rst tx",   64'(bus.Tx),       64'(1));
    chk("rst busy", 64'(bus.Busy),     64'(0));
    chk("rst full", 64'(bus.Full),     64'(0));
    chk("rst ovf",  64'(bus.Overflow), 64'(0));

    // 2: single word while idle
    write_word(32'h44332211);
    s = edge_cnt + 1;
    chk("s2 tx after push",   64'(bus.Tx),   64'(1));
    chk("s2 busy after push", 64'(bus.Busy), 64'(0));
    tick(1);
    chk("s2 tx start",   64'(bus.Tx),   64'(0));
    chk("s2 busy start", 64'(bus.Busy), 64'(1));
    check_word("s2", s, 32'h44332211);
    wait_hist(s + 170);
    chk("s2 busy cycles", 64'(busy_cnt(s - 2, s + 170)), 64'(160));
    chk("s2 tx idle", 64'(tx_hist[s + 160]), 64'(1));

    // 3: five consecutive writes
    for (int i = 0; i < 5; i++) begin
      write_word(words[i]);
      if (i == 0) s = edge_cnt + 1;
    end
    chk("s3 full", 64'(bus.Full),     64'(1));
    chk("s3 ovf",  64'(bus.Overflow), 64'(0));
    for (int i = 0; i < 5; i++) check_word($sformatf("s3 w%0d", i), s + 160 * i, words[i]);
    wait_hist(s + 820);
    chk("s3 idle after", 64'(busy_cnt(s + 800, s + 820)), 64'(0));

    // 4: six consecutive writes, sixth dropped
    for (int i = 0; i < 6; i++) begin
      write_word(words[5 - i]);
      if (i == 0) s = edge_cnt + 1;
    end
    chk("s4 ovf",  64'(bus.Overflow), 64'(1));
    chk("s4 full", 64'(bus.Full),     64'(1));
    for (int i = 0; i < 5; i++) check_word($sformatf("s4 w%0d", i), s + 160 * i, words[5 - i]);
    wait_hist(s + 840);
    chk("s4 no sixth word", 64'(busy_cnt(s + 800, s + 840)), 64'(0));
    chk("s4 ovf sticky",    64'(bus.Overflow), 64'(1));
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    chk("s4 ovf cleared", 64'(bus.Overflow), 64'(0));

    // 5: write on the same edge as a pop while full
    for (int i = 0; i < 5; i++) begin
      write_word(words[i]);
      if (i == 0) s = edge_cnt + 1;
    end
    wait_edge(s + 159);
    chk("s5 full before pop", 64'(bus.Full), 64'(1));
    chk("s5 ovf before pop",  64'(bus.Overflow), 64'(0));
    write_word(32'hBADBAD00);
    chk("s5 full after pop", 64'(bus.Full),     64'(0));
    chk("s5 ovf set",        64'(bus.Overflow), 64'(1));
    write_word(32'h600DF00D);
    chk("s5 full refill", 64'(bus.Full), 64'(1));
    for (int i = 0; i < 5; i++) check_word($sformatf("s5 w%0d", i), s + 160 * i, words[i]);
    check_word("s5 w5", s + 800, 32'h600DF00D);
    wait_hist(s + 990);
    chk("s5 idle after", 64'(busy_cnt(s + 960, s + 990)), 64'(0));

    // 6: reset during bit 3 of byte 1 with words still buffered
    write_word(32'h13570422);
    s = edge_cnt + 1;
    write_word(32'hFFFF0000);
    write_word(32'h0F0F0F0F);
    wait_edge(s + 57);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    chk("s6 tx mid bit",  64'(tx_hist[s + 57]), 64'(0));
    chk("s6 tx",          64'(bus.Tx),       64'(1));
    chk("s6 busy",        64'(bus.Busy),     64'(0));
    chk("s6 full",        64'(bus.Full),     64'(0));
    chk("s6 ovf",         64'(bus.Overflow), 64'(0));
    tick(6);
    chk("s6 fifo empty", 64'(busy_cnt(s + 58, s + 63)), 64'(0));
    write_word(32'hA5A5A5A5);
    s = edge_cnt + 1;
    check_word("s6 a5", s, 32'hA5A5A5A5);
    wait_hist(s + 170);
    chk("s6 a5 busy cycles", 64'(busy_cnt(s - 2, s + 170)), 64'(160));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/port_uart_tx.md
# port_uart_tx

Serial output stage for the single-cycle MIPS processor. It accepts 32-bit words written by the processor's output port path, buffers them in a small FIFO, and sends each word as four 8N1 UART frames on a single Tx line. It sits directly downstream of the processor top level and consumes the value the core drives onto its output port, together with a one-cycle write strobe.

## Interface
Parameters:
- CLKS_PER_BIT, default 434: clock cycles per UART bit (50 MHz / 115200). Must be ≥ 2.
- FIFO_DEPTH, default 4: number of 32-bit words buffered. Must be a power of two, ≥ 2.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- PortWrite  in  1  one-cycle write strobe from the processor.
- PortData  in  32  word to transmit; sampled on an edge where PortWrite=1.
- Tx  out  1  UART serial line (registered, idles high).
- Busy  out  1  high while the FSM is not in IDLE.
- Full  out  1  high when the FIFO holds FIFO_DEPTH words.
- Overflow  out  1  sticky flag: a write was dropped.

## Operation
- FIFO: circular buffer with read and write pointers of log2(FIFO_DEPTH) bits that wrap naturally, plus a count from 0 to FIFO_DEPTH. Full = (count == FIFO_DEPTH); Empty = (count == 0).
- Push: on an edge with PortWrite=1, PortData is written if Full is 0 before that edge. If Full is 1, the word is dropped and Overflow is set to 1. Overflow clears only on reset.
- Pop and push on the same edge: both take effect, and count is unchanged. A pop never frees space for a write on that same edge, because Full is evaluated before the edge.
- FSM states are IDLE, START, DATA and STOP.
  - IDLE: if the FIFO is not empty, pop the head word into the shift word, set byte index = 0, and go to START.
  - START: Tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index = 0.
  - DATA: Tx = bit[bit index] of the current byte for CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: Tx=1 for CLKS_PER_BIT cycles, then:
    - if byte index < 3: increment it and go to START;
    - if byte index = 3 and the FIFO is not empty: pop the next word, set byte index = 0, and go to START with no idle gap;
    - otherwise go to IDLE.
- Byte order: byte 0 = PortData[7:0] is sent first, byte 3 = PortData[31:24] last. Bits within a byte are sent LSB first.
- Baud counter runs from 0 to CLKS_PER_BIT-1. It resets to 0 on every state or bit transition.
- Busy = (state != IDLE).

## Timing
- Reset (reset=0 at an edge) gives, after that edge: Tx=1, Busy=0, Full=0, Overflow=0, FIFO empty, state IDLE, all counters 0. This applies mid-frame as well: the current frame is aborted, Tx is high from the next cycle, and buffered words are discarded.
- Latency, idle and empty case:
  - PortWrite at edge E0 pushes the word.
  - At edge E1 the word is popped and Tx goes to 0.
  - The start bit spans cycles E1 to E1+CLKS_PER_BIT-1.
- One word takes 40 × CLKS_PER_BIT cycles.
- Busy falls on the edge that ends the last stop bit when the FIFO is empty.
- Tx changes only on clock edges and never glitches.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
1. Hold reset=0 for 2 cycles, then release -> Tx=1, Busy=0, Full=0, Overflow=0.
2. Single write of 0x44332211 while idle -> Tx=0 starting one cycle after the write edge. Decoding Tx gives bytes 0x11, 0x22, 0x33, 0x44, each with start=0 and stop=1 and 4 cycles per bit. Busy stays high for exactly 160 cycles.
3. Five writes on consecutive cycles while idle -> all accepted (the first is popped at the second edge). Full=1 after the fifth write, Overflow=0. Twenty frames are emitted with no idle between words.
4. Six writes on consecutive cycles -> the sixth is dropped, Overflow=1. The output contains only the first five words. Overflow stays 1 until reset.
5. Full=1 and a pop occurs on the same edge as a write -> the write is dropped, Overflow=1, and count ends at FIFO_DEPTH-1.
6. reset=0 for one cycle during bit 3 of byte 1 -> Tx=1 from the next cycle, Busy=0, FIFO empty. A following write of 0xA5A5A5A5 transmits four clean 0xA5 frames.
